// File: rtl/tmr_error_monitor.sv
// Error-sink collector for TMR voter mismatch lines: edge-counts each source,
// keeps sticky/fatal status and streams one event per source report to a host.
module tmr_error_monitor #(
    parameter int N_SRC  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3,
    localparam int SRC_W = $clog2(N_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   err_in,
    input  logic               clear,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [SRC_W-1:0]   evt_src,
    output logic [CNT_W-1:0]   evt_count,
    output logic [N_SRC-1:0]   sticky,
    output logic               fatal,
    output logic               overflow
);

    // Stream handshake: an event transfers on a cycle where evt_valid && evt_ready;
    // while evt_valid is high and evt_ready low, evt_src/evt_count hold steady.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    logic [N_SRC-1:0] err_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending, pend_n, pend_arb;
    logic [CNT_W-1:0] cnt   [N_SRC];
    logic [CNT_W-1:0] cnt_n [N_SRC];
    logic [N_SRC-1:0] sticky_n;
    logic             fatal_n, ovf_n;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] gnt;
    logic             gnt_found;
    logic             load;
    logic             grant_fire;

    assign rise = err_in & ~err_q;
    assign load = !evt_valid || evt_ready;

    // Clear empties the pending set before arbitration, so nothing is granted
    // from pre-clear state in the clearing cycle.
    assign pend_arb   = clear ? '0 : pending;
    assign grant_fire = load && gnt_found;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        int idx;
        gnt       = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!gnt_found && pend_arb[idx]) begin
                gnt_found = 1'b1;
                gnt       = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        pend_n   = pending;
        sticky_n = sticky;
        fatal_n  = fatal;
        ovf_n    = overflow;
        for (int i = 0; i < N_SRC; i++) cnt_n[i] = cnt[i];
        if (clear) begin
            pend_n   = '0;
            sticky_n = '0;
            fatal_n  = 1'b0;
            ovf_n    = 1'b0;
            for (int i = 0; i < N_SRC; i++) cnt_n[i] = '0;
        end
        if (grant_fire) pend_n[gnt] = 1'b0;
        // A rise applies after clear and grant, so it wins over both.
        for (int i = 0; i < N_SRC; i++) begin
            if (rise[i]) begin
                if (pend_n[i]) ovf_n = 1'b1;
                pend_n[i]   = 1'b1;
                sticky_n[i] = 1'b1;
                if (cnt_n[i] != CNT_MAX) cnt_n[i] = cnt_n[i] + 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (cnt_n[i] >= THR) fatal_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= '0;
            pending  <= '0;
            sticky   <= '0;
            fatal    <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
        end else begin
            err_q    <= err_in;
            pending  <= pend_n;
            sticky   <= sticky_n;
            fatal    <= fatal_n;
            overflow <= ovf_n;
            for (int i = 0; i < N_SRC; i++) cnt[i] <= cnt_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_src    <= '0;
            evt_count  <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
        end else if (load) begin
            if (grant_fire) begin
                evt_valid  <= 1'b1;
                evt_src    <= gnt;
                evt_count  <= cnt[gnt];
                last_grant <= gnt;
            end else begin
                evt_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Directed bench for tmr_error_monitor: default instance plus a narrow-counter
// instance for saturation.
module tb_tmr_error_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] err_in;
    logic       clear;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_src;
    logic [7:0] evt_count;
    logic [3:0] sticky;
    logic       fatal;
    logic       overflow;

    logic [3:0] err_in2;
    logic       clear2;
    logic       evt_ready2;
    logic       evt_valid2;
    logic [1:0] evt_src2;
    logic [1:0] evt_count2;
    logic [3:0] sticky2;
    logic       fatal2;
    logic       overflow2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_error_monitor #(.N_SRC(4), .CNT_W(8), .THRESH(3)) dut (
        .clk(clk), .rst(rst), .err_in(err_in), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_src(evt_src),
        .evt_count(evt_count), .sticky(sticky), .fatal(fatal), .overflow(overflow)
    );

    tmr_error_monitor #(.N_SRC(4), .CNT_W(2), .THRESH(3)) dut_sat (
        .clk(clk), .rst(rst), .err_in(err_in2), .clear(clear2),
        .evt_valid(evt_valid2), .evt_ready(evt_ready2), .evt_src(evt_src2),
        .evt_count(evt_count2), .sticky(sticky2), .fatal(fatal2), .overflow(overflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_evt;
        logic [7:0] last_cnt;
        logic [1:0] sat_exp;

        rst = 1'b1; err_in = '0; clear = 1'b0; evt_ready = 1'b1;
        err_in2 = '0; clear2 = 1'b0; evt_ready2 = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", evt_valid, 0);
        chk("rst_src", evt_src, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_fatal", fatal, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sat_valid", evt_valid2, 0);

        // Simultaneous rise on sources 0 and 2
        err_in = 4'b0101; step(); err_in = '0;
        chk("sim_t1_valid", evt_valid, 0);
        step();
        chk("sim_e0_valid", evt_valid, 1);
        chk("sim_e0_src", evt_src, 0);
        chk("sim_e0_count", evt_count, 1);
        step();
        chk("sim_e1_valid", evt_valid, 1);
        chk("sim_e1_src", evt_src, 2);
        chk("sim_e1_count", evt_count, 1);
        step();
        chk("sim_idle", evt_valid, 0);
        chk("sim_sticky", sticky, 4'b0101);

        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_sticky", sticky, 0);

        // Single pulse on source 1
        err_in = 4'b0010; step(); err_in = '0;
        chk("pulse_t1_valid", evt_valid, 0);
        step();
        chk("pulse_valid", evt_valid, 1);
        chk("pulse_src", evt_src, 1);
        chk("pulse_count", evt_count, 1);
        chk("pulse_sticky", sticky, 4'b0010);
        chk("pulse_fatal", fatal, 0);
        chk("pulse_overflow", overflow, 0);
        step();
        chk("pulse_drop", evt_valid, 0);

        // Backpressure on source 3
        evt_ready = 1'b0;
        err_in = 4'b1000; step(); err_in = '0; step();
        chk("bp_held_valid", evt_valid, 1);
        chk("bp_held_src", evt_src, 3);
        chk("bp_held_count", evt_count, 1);
        err_in = 4'b1000; step(); err_in = '0; step();
        chk("bp_2nd_count", evt_count, 1);
        chk("bp_2nd_overflow", overflow, 0);
        err_in = 4'b1000; step(); err_in = '0; step();
        chk("bp_3rd_overflow", overflow, 1);
        chk("bp_3rd_fatal", fatal, 1);
        chk("bp_3rd_src", evt_src, 3);
        chk("bp_3rd_count", evt_count, 1);
        evt_ready = 1'b1; step();
        chk("bp_next_valid", evt_valid, 1);
        chk("bp_next_src", evt_src, 3);
        chk("bp_next_count", evt_count, 3);
        step();
        chk("bp_drain", evt_valid, 0);
        clear = 1'b1; step(); clear = 1'b0;
        chk("bp_clr_fatal", fatal, 0);
        chk("bp_clr_overflow", overflow, 0);

        // Level-held source 0 counts once, then threshold
        n_evt = 0; last_cnt = '0;
        err_in = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            if (evt_valid) begin n_evt++; last_cnt = evt_count; end
        end
        err_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (evt_valid) begin n_evt++; last_cnt = evt_count; end
        end
        chk("lvl_events", n_evt, 1);
        chk("lvl_count", last_cnt, 1);
        err_in = 4'b0001; step(); err_in = '0; step();
        chk("thr_e2_count", evt_count, 2);
        chk("thr_e2_fatal", fatal, 0);
        err_in = 4'b0001; step(); err_in = '0;
        chk("thr_fatal_rise", fatal, 1);
        step();
        chk("thr_e3_src", evt_src, 0);
        chk("thr_e3_count", evt_count, 3);
        step();

        // Saturation on the 2-bit counter instance
        for (int k = 0; k < 5; k++) begin
            sat_exp = (k < 3) ? 2'(k + 1) : 2'd3;
            err_in2 = 4'b0010; step(); err_in2 = '0; step();
            chk("sat_valid", evt_valid2, 1);
            chk("sat_src", evt_src2, 1);
            chk("sat_count", evt_count2, sat_exp);
            chk("sat_fatal", fatal2, (k >= 2) ? 1 : 0);
        end

        // Clear alongside a rise with an event held
        evt_ready = 1'b0;
        err_in = 4'b0010; step(); err_in = '0; step();
        chk("cl_held_src", evt_src, 1);
        clear = 1'b1; err_in = 4'b0100; step(); clear = 1'b0; err_in = '0;
        step();
        chk("cl_valid", evt_valid, 1);
        chk("cl_src", evt_src, 1);
        chk("cl_count", evt_count, 1);
        chk("cl_sticky", sticky, 4'b0100);
        chk("cl_fatal", fatal, 0);
        chk("cl_overflow", overflow, 0);
        evt_ready = 1'b1; step();
        chk("cl_next_src", evt_src, 2);
        chk("cl_next_count", evt_count, 1);
        step();
        chk("cl_drain", evt_valid, 0);

        // Reset mid-stream discards held and pending events
        evt_ready = 1'b0;
        err_in = 4'b1001; step(); err_in = '0; step();
        chk("rs_held", evt_valid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        evt_ready = 1'b1;
        chk("rs_valid", evt_valid, 0);
        chk("rs_sticky", sticky, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rs_quiet", evt_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
